// File: rtl/match_timer_n.sv
// -----------------------------------------------------------------------------
// match_timer_n
//
// Prescaled timer/counter with NCH match channels. A prescale counter (pc)
// runs from 0 to pr and produces a one-cycle tick. Each tick advances the
// timer counter (tc). On a tick, any channel whose match value equals tc
// can do four things:
//   - set its sticky interrupt flag
//   - force tc back to 0
//   - stop the timer
//   - toggle its match pin
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset of all state
//   en       in   count enable (level)
//   crst     in   counter reset (level): holds pc/tc at 0 and clears the stop latch
//   pr       in   prescale terminal value
//   mr       in   match values, channel i = mr[i*WIDTH +: WIDTH]
//   mcr      in   match control, channel i: [4i]=irq [4i+1]=reset [4i+2]=stop [4i+3]=toggle
//   ir_clr   in   write-1-to-clear per interrupt flag
//   tc       out  timer counter
//   pc       out  prescale counter
//   ir       out  sticky interrupt flags
//   irq      out  OR of ir
//   mat      out  match output pins
//   running  out  en && !crst && !halted
// -----------------------------------------------------------------------------
module match_timer_n #(
   parameter int WIDTH = 32,
   parameter int NCH   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 crst,
   input  logic [WIDTH-1:0]     pr,
   input  logic [NCH*WIDTH-1:0] mr,
   input  logic [4*NCH-1:0]     mcr,
   input  logic [NCH-1:0]       ir_clr,
   output logic [WIDTH-1:0]     tc,
   output logic [WIDTH-1:0]     pc,
   output logic [NCH-1:0]       ir,
   output logic                 irq,
   output logic [NCH-1:0]       mat,
   output logic                 running
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] tc_q, tc_d;
   logic [NCH-1:0]   ir_q, ir_d;
   logic [NCH-1:0]   mat_q, mat_d;
   logic             halted_q, halted_d;

   logic             tick;
   logic [NCH-1:0]   match;
   logic [NCH-1:0]   ir_set;
   logic [NCH-1:0]   mat_tog;
   logic             any_rst;
   logic             any_stop;

   assign running = en && !crst && !halted_q;

   // tick is gated by running, so no match can fire while stopped or in crst
   assign tick = running && (pc_q == pr);

   always_comb begin
      match    = '0;
      ir_set   = '0;
      mat_tog  = '0;
      any_rst  = 1'b0;
      any_stop = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         match[i]   = tick && (tc_q == mr[i*WIDTH +: WIDTH]);
         ir_set[i]  = match[i] && mcr[4*i+0];
         mat_tog[i] = match[i] && mcr[4*i+3];
         if (match[i] && mcr[4*i+1]) any_rst  = 1'b1;
         if (match[i] && mcr[4*i+2]) any_stop = 1'b1;
      end
   end

   always_comb begin
      pc_d     = pc_q;
      tc_d     = tc_q;
      halted_d = halted_q;
      if (crst) begin
         pc_d     = '0;
         tc_d     = '0;
         halted_d = 1'b0;
      end else if (running) begin
         pc_d = tick ? '0 : pc_q + WIDTH'(1);
         if (tick) tc_d = any_rst ? '0 : tc_q + WIDTH'(1);
         // Stopping parks the prescaler at 0 so a restart begins a full period
         if (any_stop) begin
            halted_d = 1'b1;
            pc_d     = '0;
         end
      end
      // A new set wins over a simultaneous clear
      ir_d  = (ir_q & ~ir_clr) | ir_set;
      mat_d = mat_q ^ mat_tog;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= '0;
         tc_q     <= '0;
         ir_q     <= '0;
         mat_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         tc_q     <= tc_d;
         ir_q     <= ir_d;
         mat_q    <= mat_d;
         halted_q <= halted_d;
      end
   end

   assign tc  = tc_q;
   assign pc  = pc_q;
   assign ir  = ir_q;
   assign mat = mat_q;
   assign irq = |ir_q;

endmodule

// File: tb/tb_match_timer_n.sv
// -----------------------------------------------------------------------------
// tb_match_timer_n
//
// Bench for match_timer_n (WIDTH=8, NCH=4). A behavioural model tracks the
// timer with plain integer arithmetic; every cycle all outputs are compared
// against it, and the directed scenarios add explicit expected constants.
// -----------------------------------------------------------------------------
module tb_match_timer_n;

   localparam int W   = 8;
   localparam int N   = 4;
   localparam int MOD = 1 << W;

   logic           clk = 1'b0;
   logic           reset, en, crst;
   logic [W-1:0]   pr;
   logic [N*W-1:0] mr;
   logic [4*N-1:0] mcr;
   logic [N-1:0]   ir_clr;
   logic [W-1:0]   tc, pc;
   logic [N-1:0]   ir, mat;
   logic           irq, running;

   int n_chk = 0;
   int n_err = 0;

   // model state
   int       m_pc, m_tc;
   bit       m_halt;
   bit [N-1:0] m_ir, m_mat;

   match_timer_n #(.WIDTH(W), .NCH(N)) dut (
      .clk(clk), .reset(reset), .en(en), .crst(crst), .pr(pr), .mr(mr),
      .mcr(mcr), .ir_clr(ir_clr), .tc(tc), .pc(pc), .ir(ir), .irq(irq),
      .mat(mat), .running(running)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Next-state model built from the timer's behavioural rules
   task automatic model_step();
      bit tk, rstm, stp;
      bit [N-1:0] set, tog;
      set = '0; tog = '0; rstm = 0; stp = 0;
      if (reset) begin
         m_pc = 0; m_tc = 0; m_halt = 0; m_ir = '0; m_mat = '0;
         return;
      end
      if (crst) begin
         m_pc = 0; m_tc = 0; m_halt = 0;
      end else if (en && !m_halt) begin
         tk = (m_pc == int'(pr));
         if (tk) begin
            for (int c = 0; c < N; c++) begin
               if (m_tc == int'(mr[c*W +: W])) begin
                  if (mcr[4*c+0]) set[c] = 1'b1;
                  if (mcr[4*c+1]) rstm = 1'b1;
                  if (mcr[4*c+2]) stp = 1'b1;
                  if (mcr[4*c+3]) tog[c] = 1'b1;
               end
            end
            m_pc = 0;
            m_tc = rstm ? 0 : (m_tc + 1) % MOD;
         end else begin
            m_pc = (m_pc + 1) % MOD;
         end
         if (stp) begin
            m_halt = 1'b1;
            m_pc = 0;
         end
      end
      m_ir  = (m_ir & ~ir_clr) | set;
      m_mat = m_mat ^ tog;
   endtask

   task automatic cyc(input bit rs, input bit e, input bit cr, input logic [N-1:0] clr);
      @(negedge clk);
      reset = rs; en = e; crst = cr; ir_clr = clr;
      model_step();
      @(posedge clk);
      #1;
      check("tc", tc, m_tc);
      check("pc", pc, m_pc);
      check("ir", ir, m_ir);
      check("mat", mat, m_mat);
      check("irq", irq, |m_ir);
      check("running", running, en && !crst && !m_halt);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cyc(0, 1, 0, '0);
   endtask

   initial begin
      reset = 1; en = 0; crst = 0; pr = '0; mr = '0; mcr = '0; ir_clr = '0;
      m_pc = 0; m_tc = 0; m_halt = 0; m_ir = '0; m_mat = '0;

      // reset state
      cyc(1, 0, 0, '0);
      cyc(1, 1, 1, '0);
      check("rst tc", tc, 0);
      check("rst ir", ir, 0);
      check("rst mat", mat, 0);

      // prescale 2: tick every third cycle
      pr = 8'd2; mcr = '0;
      cyc(1, 0, 0, '0);
      run(12);
      check("pr2 tc", tc, 4);

      // interrupt + reset match on channel 0 at 5
      pr = 8'd0; mr = '0; mr[0*W +: W] = 8'd5; mr[1*W +: W] = 8'hff;
      mr[2*W +: W] = 8'hff; mr[3*W +: W] = 8'hff; mcr = 16'h0003;
      cyc(1, 0, 0, '0);
      run(5);
      check("m0 tc5", tc, 5);
      check("m0 ir0 pre", ir[0], 0);
      run(1);
      check("m0 tc0", tc, 0);
      check("m0 ir0", ir[0], 1);
      check("m0 irq", irq, 1);
      // clear coinciding with a new set: set wins
      run(5);
      cyc(0, 1, 0, 4'b0001);
      check("clr race tc", tc, 0);
      check("clr race ir0", ir[0], 1);
      cyc(0, 1, 0, 4'b0001);
      check("clr idle ir0", ir[0], 0);

      // stop match on channel 1 at 3
      mr[0*W +: W] = 8'hff; mr[1*W +: W] = 8'd3; mcr = 16'h0040;
      cyc(1, 0, 0, '0);
      run(6);
      check("stop tc", tc, 4);
      check("stop pc", pc, 0);
      check("stop running", running, 0);
      cyc(0, 0, 0, '0);
      cyc(0, 1, 0, '0);
      check("stop held tc", tc, 4);
      cyc(0, 1, 1, '0);
      check("crst tc", tc, 0);
      cyc(0, 1, 0, '0);
      check("restart running", running, 1);
      check("restart tc", tc, 1);

      // shared match value: ch0 reset, ch2 toggle + interrupt
      mr[0*W +: W] = 8'd7; mr[1*W +: W] = 8'hff; mr[2*W +: W] = 8'd7; mcr = 16'h0902;
      cyc(1, 0, 0, '0);
      run(8);
      check("dual tc", tc, 0);
      check("dual mat2", mat[2], 1);
      check("dual ir2", ir[2], 1);
      run(8);
      check("dual mat2 again", mat[2], 0);

      // wrap at 255 with no matches enabled, then reset mid-count
      mcr = '0; pr = 8'd0;
      cyc(1, 0, 0, '0);
      run(255);
      check("wrap tc255", tc, 255);
      run(1);
      check("wrap tc0", tc, 0);
      check("wrap ir", ir, 0);
      run(100);
      check("pre-rst tc", tc, 100);
      cyc(1, 1, 0, '0);
      check("mid rst tc", tc, 0);
      check("mid rst pc", pc, 0);
      check("mid rst ir", ir, 0);
      check("mid rst mat", mat, 0);
      run(1);
      check("post rst tc", tc, 1);

      // randomized traffic
      for (int k = 0; k < 2000; k++) begin
         if (k % 50 == 0) begin
            pr  = W'($urandom_range(0, 3));
            mcr = 16'($urandom);
            for (int c = 0; c < N; c++) mr[c*W +: W] = W'($urandom_range(0, 20));
         end
         cyc(($urandom % 200) == 0, ($urandom % 8) != 0, ($urandom % 40) == 0,
             N'($urandom) & N'($urandom) & N'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/match_timer_n.md
MATCH_TIMER_N -- requirements
Module: match_timer_n

Interface
REQ-001 Parameter WIDTH, default 32: width of the prescale counter, timer counter, prescale value and each match value.
REQ-002 Parameter NCH, default 4: number of match channels, 1..8.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  count enable (level).
REQ-006 crst  input  1  counter reset (level); holds PC/TC at 0 while high.
REQ-007 pr  input  WIDTH  prescale terminal value.
REQ-008 mr  input  NCH*WIDTH  match values; channel i = mr[i*WIDTH +: WIDTH].
REQ-009 mcr  input  4*NCH  match control; channel i bits [4i+0]=interrupt, [4i+1]=reset TC, [4i+2]=stop, [4i+3]=toggle mat.
REQ-010 ir_clr  input  NCH  write-1-to-clear pulse per interrupt flag.
REQ-011 tc  output  WIDTH  timer counter value.
REQ-012 pc  output  WIDTH  prescale counter value.
REQ-013 ir  output  NCH  sticky interrupt flags.
REQ-014 irq  output  1  OR of all ir bits (combinational).
REQ-015 mat  output  NCH  match output pins.
REQ-016 running  output  1  en && !crst && !halted, where halted is an internal stop latch.

Function
REQ-017 Single clock domain; no derived or gated clocks; TC advances on an internal one-cycle tick.
REQ-018 When running: pc==pr -> pc<=0 and tick=1 this cycle; else pc<=pc+1, tick=0.
REQ-019 pr==0 -> tick every running cycle (TC counts at clk rate).
REQ-020 On tick, with no reset-match, tc<=tc+1, wrapping from all-ones to 0 silently.
REQ-021 Match event for channel i = tick && (tc == mr_i), evaluated combinationally in the tick cycle; all effects visible in the following cycle.
REQ-022 Match with interrupt bit set -> ir[i]<=1.
REQ-023 Match with reset bit set -> tc<=0 instead of tc+1.
REQ-024 Match with stop bit set -> halted<=1, pc<=0, and tc takes the value it would otherwise take (0 if a reset-match also occurs, else tc+1).
REQ-025 Match with toggle bit set -> mat[i]<=~mat[i].
REQ-026 Multiple channels matching in one cycle: all effects apply independently; any reset-match forces tc<=0; any stop-match sets halted.
REQ-027 ir_clr[i] and set of ir[i] in the same cycle -> set wins, so ir[i] stays 1.
REQ-028 Not running (en=0, or halted): pc, tc, ir and mat hold; ir_clr still functional.
REQ-029 crst=1 -> pc<=0, tc<=0, halted<=0; ir and mat unaffected; no match events while crst is high.
REQ-030 halted clears only on crst or reset; en toggling does not clear it.
REQ-031 pr, mr and mcr are sampled live each cycle; a change takes effect on the next comparison.

Reset
REQ-032 reset=1 -> pc=0, tc=0, ir=0, mat=0, halted=0 on the next edge; reset overrides crst, en and any match.
REQ-033 Reset asserted mid-count clears all state within one cycle; counting resumes from 0 on the first edge after reset deasserts if en=1.

Verification
REQ-034 pr=2, en=1, no matches -> tick every 3rd cycle; tc reaches 4 after 12 running cycles.
REQ-035 pr=0, mr0=5, mcr ch0=interrupt+reset -> tc sequence 0..5,0,1...; ir[0]=1 the cycle after tc=5; irq=1.
REQ-036 pr=0, mr1=3, mcr ch1=stop -> tc stops at 4, running=0, pc=0; crst pulse -> tc=0, running=1.
REQ-037 mr0=mr2=7, ch0=reset, ch2=toggle+interrupt -> after tc=7: tc=0, mat[2]=1, ir[2]=1; mat[2]=0 after the next match.
REQ-038 ir[0]=1; ir_clr[0]=1 in the same cycle as a new ch0 interrupt match -> ir[0] remains 1; ir_clr[0] on a later idle cycle -> ir[0]=0.
REQ-039 WIDTH=8, pr=0, no matches -> tc wraps 255->0 with no ir change; reset asserted at tc=100 -> all outputs 0 on the next edge.
